shift_row_stream: RTL and testbench

//  Byte-serial AES ShiftRows for the encryption datapath (forward direction, out(r,c) = in(r,(c+r)%4)).

---
 rtl/aes_pkg.sv | 27 ++
 rtl/shift_row_buf.sv | 71 +++++++
 rtl/shift_row_stream.sv | 109 ++++++++++
 tb/tb_shift_row_stream.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte/state types and the ShiftRows source-index helper.
// Source index for output byte k: row r = k%4 stays put, column shifts by r (left for forward, right for inverse).
package aes_pkg;
    localparam int AES_NB          = 4;
    localparam int AES_STATE_BYTES = 16;

    typedef logic [7:0] aes_byte_t;
    typedef aes_byte_t [AES_STATE_BYTES-1:0] aes_state_t;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_FILL,
        BUF_FULL,
        BUF_DRAIN
    } buf_state_t;

    function automatic logic [3:0] shift_row_idx(input logic [3:0] k, input logic inv);
        logic [1:0] row;
        logic [1:0] col;
        logic [1:0] src_col;
        row = k[1:0];
        col = k[3:2];
        // 2-bit arithmetic gives the mod-AES_NB column wrap for free
        src_col = inv ? (col - row) : (col + row);
        return {src_col, row};
    endfunction
endpackage

// File: rtl/shift_row_buf.sv
// One 16-byte AES state buffer with its own fill/drain FSM.
// With SHIFT_ROW_INV_EN defined, also holds the per-block inverse flag captured with byte 0.
//
// state     | meaning
// BUF_EMPTY | no data, ready for byte 0
// BUF_FILL  | some bytes of a block written
// BUF_FULL  | complete block, nothing read yet
// BUF_DRAIN | block being read out
module shift_row_buf
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_idx,
    input  aes_byte_t  wr_byte,
    input  logic       wr_last,
`ifdef SHIFT_ROW_INV_EN
    input  logic       wr_inv,
    output logic       rd_inv,
`endif
    input  logic       rd_en,
    input  logic       rd_last,
    input  logic [3:0] rd_sel,
    output aes_byte_t  rd_byte,
    output logic       wr_open,
    output logic       rd_avail
);
    buf_state_t state, state_nxt;
    aes_state_t mem;
    logic       wr_done;
    logic       discard;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= BUF_EMPTY;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_byte;
    end

`ifdef SHIFT_ROW_INV_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                       rd_inv <= 1'b0;
        else if (wr_en && wr_idx == 4'd0) rd_inv <= wr_inv;
    end
`endif

    always_comb begin
        state_nxt = state;
        wr_done   = wr_en && (wr_idx == 4'd15);
        discard   = wr_en && wr_last && !wr_done;
        case (state)
            BUF_EMPTY: if (wr_en && !discard) state_nxt = BUF_FILL;
            BUF_FILL: begin
                if (discard)      state_nxt = BUF_EMPTY;
                else if (wr_done) state_nxt = rd_en ? BUF_DRAIN : BUF_FULL;
            end
            BUF_FULL:  if (rd_en) state_nxt = rd_last ? BUF_EMPTY : BUF_DRAIN;
            BUF_DRAIN: if (rd_en && rd_last) state_nxt = BUF_EMPTY;
            default:   state_nxt = BUF_EMPTY;
        endcase
    end

    assign rd_byte  = mem[rd_sel];
    assign wr_open  = (state == BUF_EMPTY) || (state == BUF_FILL);
    // Byte 0 is already stored when byte 15 arrives, so reading may start on that same cycle.
    assign rd_avail = (state == BUF_FULL) || (state == BUF_DRAIN) ||
                      ((state == BUF_FILL) && wr_done);
endmodule

// File: rtl/shift_row_stream.sv
// Byte-serial AES ShiftRows with NBUF (1 or 2) ping-pong state buffers and a registered output byte.
// Define SHIFT_ROW_INV_EN to add the in_inv port selecting the inverse mapping per block.
module shift_row_stream
    import aes_pkg::*;
#(
    parameter int NBUF = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  aes_byte_t in_byte,
    input  logic      in_valid,
    input  logic      in_last,
`ifdef SHIFT_ROW_INV_EN
    input  logic      in_inv,
`endif
    output logic      in_ready,
    output aes_byte_t out_byte,
    output logic      out_valid,
    output logic      out_last,
    input  logic      out_ready,
    output logic      err
);
    logic            wr_ptr;
    logic            rd_ptr;
    logic [3:0]      wr_cnt;
    logic [3:0]      rd_cnt;
    logic [3:0]      rd_sel;
    logic [NBUF-1:0] buf_open;
    logic [NBUF-1:0] buf_avail;
    logic [NBUF-1:0] buf_wr_en;
    logic [NBUF-1:0] buf_rd_en;
    aes_byte_t       buf_rd_byte [NBUF];
    logic            accept;
    logic            discard;
    logic            out_load;

`ifdef SHIFT_ROW_INV_EN
    logic [NBUF-1:0] buf_inv;
    assign rd_sel = shift_row_idx(rd_cnt, buf_inv[rd_ptr]);
`else
    assign rd_sel = shift_row_idx(rd_cnt, 1'b0);
`endif

    assign in_ready = rst_n && buf_open[wr_ptr];
    assign accept   = in_valid && in_ready;
    assign discard  = accept && in_last && (wr_cnt != 4'd15);
    assign out_load = buf_avail[rd_ptr] && (!out_valid || out_ready);

    always_comb begin
        buf_wr_en         = '0;
        buf_rd_en         = '0;
        buf_wr_en[wr_ptr] = accept;
        buf_rd_en[rd_ptr] = out_load;
    end

    for (genvar i = 0; i < NBUF; i++) begin : g_buf
        shift_row_buf u_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (buf_wr_en[i]),
            .wr_idx   (wr_cnt),
            .wr_byte  (in_byte),
            .wr_last  (in_last),
`ifdef SHIFT_ROW_INV_EN
            .wr_inv   (in_inv),
            .rd_inv   (buf_inv[i]),
`endif
            .rd_en    (buf_rd_en[i]),
            .rd_last  (rd_cnt == 4'd15),
            .rd_sel   (rd_sel),
            .rd_byte  (buf_rd_byte[i]),
            .wr_open  (buf_open[i]),
            .rd_avail (buf_avail[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_cnt    <= 4'd0;
            rd_cnt    <= 4'd0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= discard;
            if (accept) begin
                if (discard) begin
                    wr_cnt <= 4'd0;
                end else begin
                    wr_cnt <= wr_cnt + 4'd1;
                    if (wr_cnt == 4'd15) wr_ptr <= (NBUF == 2) ? ~wr_ptr : 1'b0;
                end
            end
            if (out_load) begin
                out_byte  <= buf_rd_byte[rd_ptr];
                out_valid <= 1'b1;
                out_last  <= (rd_cnt == 4'd15);
                rd_cnt    <= rd_cnt + 4'd1;
                if (rd_cnt == 4'd15) rd_ptr <= (NBUF == 2) ? ~rd_ptr : 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shift_row_stream.sv
// Self-checking bench for shift_row_stream: directed vectors plus random traffic against a row/column model.
// Honours SHIFT_ROW_INV_EN to exercise the inverse mapping.
module tb_shift_row_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_last;
    logic       in_inv_d;
    logic       in_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       err;

`ifdef SHIFT_ROW_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    shift_row_stream #(.NBUF(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_last   (in_last),
`ifdef SHIFT_ROW_INV_EN
        .in_inv    (in_inv_d),
`endif
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err       (err)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] cur_q [$];
    logic [7:0] got_q [$];
    logic       cur_inv;
    logic       err_exp;
    logic       stall_prev;
    logic [7:0] prev_byte;
    logic       prev_last;
    logic       acc_o;
    logic       xfer_o;
    int         out_idx;
    int         cyc;
    int         n_out;
    int         first_out_cyc;
    int         last_out_cyc;
    int         not_acc;

    logic [7:0] fips_in  [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                                  8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    logic [7:0] fips_out [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                                  8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
    logic [7:0] ramp_fwd [16] = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                                  8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};
    logic [7:0] ramp_inv [16] = '{8'h00, 8'h0d, 8'h0a, 8'h07, 8'h04, 8'h01, 8'h0e, 8'h0b,
                                  8'h08, 8'h05, 8'h02, 8'h0f, 8'h0c, 8'h09, 8'h06, 8'h03};
    logic [7:0] ramp     [16];
    logic [7:0] rnd      [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: state[row][col]; out(r,c) = in(r,(c+r)%4) forward, in(r,(c-r)%4) inverse.
    task automatic model_accept(input logic [7:0] b, input logic last, input logic inv);
        logic [7:0] st [4][4];
        if (cur_q.size() == 0) cur_inv = inv;
        cur_q.push_back(b);
        if (cur_q.size() == 16) begin
            for (int k = 0; k < 16; k++) st[k % 4][k / 4] = cur_q[k];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    exp_q.push_back(st[r][cur_inv ? (c - r + 4) % 4 : (c + r) % 4]);
            cur_q.delete();
        end else if (last) begin
            cur_q.delete();
            err_exp = 1'b1;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic last,
                        input logic inv, input logic ordy);
        in_valid  = v;
        in_byte   = b;
        in_last   = last;
        in_inv_d  = inv;
        out_ready = ordy;
        #1;
        acc_o  = in_valid && in_ready;
        xfer_o = out_valid && out_ready;
        chk("err", err, err_exp);
        err_exp = 1'b0;
        if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_byte", out_byte, prev_byte);
            chk("stall_last", out_last, prev_last);
        end
        if (xfer_o) begin
            chk("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                chk("out_byte", out_byte, exp_q.pop_front());
                chk("out_last", out_last, out_idx == 15);
            end
            got_q.push_back(out_byte);
            out_idx = (out_idx + 1) % 16;
            if (n_out == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            n_out++;
        end
        stall_prev = out_valid && !out_ready;
        prev_byte  = out_byte;
        prev_last  = out_last;
        if (acc_o) model_accept(in_byte, in_last, in_inv_d);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic feed_block(input logic [7:0] blk [16], input int last_at, input logic inv,
                              input int vpct, input int rpct);
        int i     = 0;
        int guard = 0;
        logic v;
        while (i <= last_at && guard < 400) begin
            v = ($urandom_range(99) < vpct);
            step(v, blk[i], i == last_at, inv, $urandom_range(99) < rpct);
            if (acc_o) i++;
            else if (v) not_acc++;
            guard++;
        end
        chk("feed_timeout", i > last_at, 1);
    endtask

    task automatic drain(input int rpct);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, $urandom_range(99) < rpct);
            guard++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("no_extra_out", out_valid, 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_byte", out_byte, 8'h00);
        chk("rst_err", err, 0);
        chk("rst_in_ready_after", in_ready, 1);
        exp_q.delete();
        cur_q.delete();
        err_exp    = 1'b0;
        stall_prev = 1'b0;
        out_idx    = 0;
    endtask

    task automatic rand_block();
        for (int k = 0; k < 16; k++) rnd[k] = 8'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        in_inv_d = 1'b0; out_ready = 1'b0;
        err_exp = 1'b0; stall_prev = 1'b0; out_idx = 0; cyc = 0; n_out = 0;
        first_out_cyc = 0; last_out_cyc = 0; not_acc = 0; cur_inv = 1'b0;
        prev_byte = 8'h00; prev_last = 1'b0;
        for (int k = 0; k < 16; k++) ramp[k] = 8'(k);

        @(negedge clk);
        do_reset();

        // FIPS-197 round 1 vector, latency and literal output
        got_q.delete();
        feed_block(fips_in, 15, 1'b0, 100, 100);
        chk("latency_out_valid", out_valid, 1);
        drain(100);
        chk("fips_count", got_q.size(), 16);
        for (int k = 0; k < 16 && k < got_q.size(); k++) chk("fips_out", got_q[k], fips_out[k]);

        // four back-to-back blocks at full rate
        not_acc = 0;
        n_out   = 0;
        for (int b = 0; b < 4; b++) begin
            rand_block();
            feed_block(rnd, 15, 1'b0, 100, 100);
        end
        drain(100);
        chk("b2b_in_ready_drop", not_acc, 0);
        chk("b2b_out_count", n_out, 64);
        chk("b2b_out_span", last_out_cyc - first_out_cyc + 1, 64);

        // backpressure: both buffers occupied, then random traffic
        for (int b = 0; b < 2; b++) begin
            rand_block();
            feed_block(rnd, 15, 1'b0, 100, 0);
        end
        chk("both_full_in_ready", in_ready, 0);
        chk("both_full_out_valid", out_valid, 1);
        for (int b = 0; b < 4; b++) begin
            rand_block();
            feed_block(rnd, 15, INV_EN ? 1'($urandom_range(1)) : 1'b0, 50, 50);
        end
        drain(50);

        // short block discarded with err, then ramp block
        got_q.delete();
        rand_block();
        feed_block(rnd, 6, 1'b0, 100, 100);
        chk("short_err", err, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        feed_block(ramp, 15, 1'b0, 100, 100);
        drain(100);
        chk("short_then_ramp_count", got_q.size(), 16);
        for (int k = 0; k < 16 && k < got_q.size(); k++) chk("ramp_fwd_out", got_q[k], ramp_fwd[k]);

        // reset with one block mid-drain and the next 9 bytes loaded
        rand_block();
        feed_block(rnd, 15, 1'b0, 100, 100);
        rand_block();
        for (int k = 0; k < 9; k++) step(1'b1, rnd[k], 1'b0, 1'b0, 1'b1);
        do_reset();
        got_q.delete();
        rand_block();
        feed_block(rnd, 15, 1'b0, 100, 100);
        drain(100);
        chk("post_reset_count", got_q.size(), 16);

`ifdef SHIFT_ROW_INV_EN
        got_q.delete();
        feed_block(ramp, 15, 1'b1, 100, 100);
        feed_block(ramp, 15, 1'b0, 100, 100);
        drain(100);
        chk("inv_count", got_q.size(), 32);
        for (int k = 0; k < 16 && k < got_q.size(); k++) chk("ramp_inv_out", got_q[k], ramp_inv[k]);
        for (int k = 16; k < 32 && k < got_q.size(); k++) chk("ramp_fwd_after_inv", got_q[k], ramp_fwd[k-16]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
